// File: rtl/ap_mon_pkg.sv
// Shared types and constants for the HLS block-level handshake status monitor.
package ap_mon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY      = 2'd1,
      DONE_WAIT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      F_TXN      = 3'd0,
      F_BUSY     = 3'd1,
      F_STALL    = 3'd2,
      F_LAST_LAT = 3'd3,
      F_MAX_LAT  = 3'd4,
      F_MIN_LAT  = 3'd5,
      F_READY    = 3'd6
   } field_t;

   localparam int NUM_FIELDS = 7;

endpackage

// File: rtl/ap_status_chan.sv
// One monitored channel: handshake FSM plus saturating transaction, busy,
// stall, latency and ready statistics.
module ap_status_chan
   import ap_mon_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                ready,
   input  logic                                done,
   input  logic                                cont,
   input  logic                                finish,
   input  logic                                clr,
   output logic [NUM_FIELDS-1:0][CNT_W-1:0]    stats,
   output state_t                              state
);

   localparam logic [CNT_W-1:0] ONES = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == ONES) ? v : v + ONE;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] lat_q, lat_d, lat_inc, done_lat;
   logic             complete, busy_inc, stall_inc;
   logic [CNT_W-1:0] txn_q, busy_q, stall_q, last_q, max_q, min_q, ready_q;

   // done_lat is the latency a completion reports; it is frozen at the
   // done cycle so DONE_WAIT cycles never count towards it.
   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      lat_inc   = sat_inc(lat_q);
      done_lat  = lat_q;
      complete  = 1'b0;
      busy_inc  = 1'b0;
      stall_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               lat_d    = ONE;
               done_lat = ONE;
               if (done && cont) complete = 1'b1;
               else if (done)    state_d  = DONE_WAIT;
               else              state_d  = BUSY;
            end
         end
         BUSY: begin
            busy_inc = 1'b1;
            lat_d    = lat_inc;
            done_lat = lat_inc;
            if (done && cont) begin
               complete = 1'b1;
               if (start) lat_d   = ONE;
               else       state_d = IDLE;
            end else if (done) begin
               state_d = DONE_WAIT;
            end
         end
         DONE_WAIT: begin
            stall_inc = 1'b1;
            if (cont) begin
               complete = 1'b1;
               if (start) begin
                  state_d = BUSY;
                  lat_d   = ONE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         lat_q   <= '0;
         txn_q   <= '0;
         busy_q  <= '0;
         stall_q <= '0;
         last_q  <= '0;
         max_q   <= '0;
         min_q   <= ONES;
         ready_q <= '0;
      end else begin
         state_q <= state_d;
         if (!finish) lat_q <= lat_d;
         if (clr) begin
            txn_q   <= '0;
            busy_q  <= '0;
            stall_q <= '0;
            last_q  <= '0;
            max_q   <= '0;
            min_q   <= ONES;
            ready_q <= '0;
         end else if (!finish) begin
            if (busy_inc)  busy_q  <= sat_inc(busy_q);
            if (stall_inc) stall_q <= sat_inc(stall_q);
            if (ready)     ready_q <= sat_inc(ready_q);
            if (complete) begin
               txn_q  <= sat_inc(txn_q);
               last_q <= done_lat;
               if (done_lat > max_q) max_q <= done_lat;
               if (done_lat < min_q) min_q <= done_lat;
            end
         end
      end
   end

   assign stats[F_TXN]      = txn_q;
   assign stats[F_BUSY]     = busy_q;
   assign stats[F_STALL]    = stall_q;
   assign stats[F_LAST_LAT] = last_q;
   assign stats[F_MAX_LAT]  = max_q;
   assign stats[F_MIN_LAT]  = min_q;
   assign stats[F_READY]    = ready_q;
   assign state             = state_q;

endmodule

// File: rtl/ap_status_monitor.sv
// Passive monitor of NUM_CH ap_start/ap_ready/ap_done/ap_continue handshakes
// with an on-chip register-style statistics read port.
module ap_status_monitor
   import ap_mon_pkg::*;
#(
   parameter int NUM_CH = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_CH-1:0] ap_start,
   input  logic [NUM_CH-1:0] ap_ready,
   input  logic [NUM_CH-1:0] ap_done,
   input  logic [NUM_CH-1:0] ap_continue,
   input  logic              finish,
   input  logic              clr,
   input  logic              rd_req,
   input  logic [4:0]        rd_ch,
   input  logic [2:0]        rd_sel,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_err,
   output logic [NUM_CH-1:0] all_idle
);

   logic [NUM_CH-1:0][NUM_FIELDS-1:0][CNT_W-1:0] stats;
   state_t                                       chan_state [NUM_CH];
   logic                                         rd_bad;
   logic [CNT_W-1:0]                             rd_mux;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      ap_status_chan #(.CNT_W(CNT_W)) u_chan (
         .clock  (clock),
         .reset  (reset),
         .start  (ap_start[i]),
         .ready  (ap_ready[i]),
         .done   (ap_done[i]),
         .cont   (ap_continue[i]),
         .finish (finish),
         .clr    (clr),
         .stats  (stats[i]),
         .state  (chan_state[i])
      );
      assign all_idle[i] = (chan_state[i] == IDLE);
   end

   always_comb begin
      rd_bad = (int'(rd_ch) >= NUM_CH) || (rd_sel > F_READY);
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int f = 0; f < NUM_FIELDS; f++) begin
            if (rd_ch == 5'(c) && rd_sel == 3'(f)) rd_mux = stats[c][f];
         end
      end
   end

   // Read port: a request sampled at an edge yields a one-cycle rd_valid
   // pulse in the next cycle; there is no backpressure, so requests may be
   // issued every cycle and each one is answered exactly once.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req && rd_bad;
         rd_data  <= (rd_req && !rd_bad) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_ap_status_monitor.sv
// Bench for ap_status_monitor: a 32-bit and a 4-bit instance share stimulus
// and are compared against a behavioural statistics model every cycle.
module tb_ap_status_monitor;

   localparam int NCH = 5;

   logic           clock;
   logic           reset;
   logic [NCH-1:0] ap_start, ap_ready, ap_done, ap_continue;
   logic           finish, clr, rd_req;
   logic [4:0]     rd_ch;
   logic [2:0]     rd_sel;
   logic           rd_valid0, rd_err0, rd_valid1, rd_err1;
   logic [31:0]    rd_data0;
   logic [3:0]     rd_data1;
   logic [NCH-1:0] all_idle0, all_idle1;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];

   bit     m_act  [2][NCH];
   bit     m_wait [2][NCH];
   longint m_cur  [2][NCH];
   longint st     [2][NCH][7];
   longint mx     [2];

   typedef struct {
      int          ch;
      int          sel;
      logic [31:0] data;
      logic        err;
   } vec_t;
   vec_t vecs [11];

   ap_status_monitor #(.NUM_CH(NCH), .CNT_W(32)) u_dut (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clr(clr),
      .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rd_valid0),
      .rd_data(rd_data0), .rd_err(rd_err0), .all_idle(all_idle0)
   );

   ap_status_monitor #(.NUM_CH(NCH), .CNT_W(4)) u_sat (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .clr(clr),
      .rd_req(rd_req), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_valid(rd_valid1),
      .rd_data(rd_data1), .rd_err(rd_err1), .all_idle(all_idle1)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void check(string name, logic [63:0] act, logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, want);
      end
   endfunction

   // behavioural model
   function automatic longint sat(longint v, longint m);
      return (v + 1 > m) ? m : v + 1;
   endfunction

   function automatic void clear_stats(int k, int i);
      for (int f = 0; f < 7; f++) st[k][i][f] = 0;
      st[k][i][5] = mx[k];
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NCH; i++) begin
            m_act[k][i]  = 1'b0;
            m_wait[k][i] = 1'b0;
            m_cur[k][i]  = 0;
            clear_stats(k, i);
         end
      end
   endfunction

   function automatic void model_step();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NCH; i++) begin
            bit     s, d, c, in_busy, in_wait, comp;
            longint lat;
            s       = ap_start[i];
            d       = ap_done[i];
            c       = ap_continue[i];
            in_wait = m_wait[k][i];
            in_busy = m_act[k][i] && !m_wait[k][i];
            comp    = 1'b0;
            lat     = 0;
            if (in_wait) begin
               lat = m_cur[k][i];
               if (c) begin
                  comp         = 1'b1;
                  m_wait[k][i] = 1'b0;
                  m_act[k][i]  = s;
                  if (s && !finish) m_cur[k][i] = 1;
               end
            end else if (in_busy) begin
               lat = (m_cur[k][i] + 1 > mx[k]) ? mx[k] : m_cur[k][i] + 1;
               if (!finish) m_cur[k][i] = lat;
               if (d && c) begin
                  comp        = 1'b1;
                  m_act[k][i] = s;
                  if (s && !finish) m_cur[k][i] = 1;
               end else if (d) begin
                  m_wait[k][i] = 1'b1;
               end
            end else if (s) begin
               lat         = 1;
               m_act[k][i] = 1'b1;
               if (!finish) m_cur[k][i] = 1;
               if (d && c) begin
                  comp        = 1'b1;
                  m_act[k][i] = 1'b0;
               end else if (d) begin
                  m_wait[k][i] = 1'b1;
               end
            end
            if (clr) begin
               clear_stats(k, i);
            end else if (!finish) begin
               if (in_busy)     st[k][i][1] = sat(st[k][i][1], mx[k]);
               if (in_wait)     st[k][i][2] = sat(st[k][i][2], mx[k]);
               if (ap_ready[i]) st[k][i][6] = sat(st[k][i][6], mx[k]);
               if (comp) begin
                  st[k][i][0] = sat(st[k][i][0], mx[k]);
                  st[k][i][3] = lat;
                  if (lat > st[k][i][4]) st[k][i][4] = lat;
                  if (lat < st[k][i][5]) st[k][i][5] = lat;
               end
            end
         end
      end
   endfunction

   function automatic logic [32:0] exp_read(int k);
      if (rd_ch >= NCH || rd_sel > 6) return {1'b1, 32'd0};
      return {1'b0, 32'(st[k][rd_ch][rd_sel])};
   endfunction

   // driver tasks
   task automatic cycle();
      bit          pend;
      logic [32:0] e;
      pend = rd_req && reset;
      if (pend) for (int k = 0; k < 2; k++) exp_q.push_back(exp_read(k));
      if (!reset) model_reset();
      else        model_step();
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         logic           vld, er;
         logic [31:0]    dat;
         logic [NCH-1:0] idl, want_idl;
         vld = (k == 0) ? rd_valid0 : rd_valid1;
         er  = (k == 0) ? rd_err0   : rd_err1;
         dat = (k == 0) ? rd_data0  : {28'd0, rd_data1};
         idl = (k == 0) ? all_idle0 : all_idle1;
         for (int i = 0; i < NCH; i++) want_idl[i] = !m_act[k][i];
         if (pend) begin
            e = exp_q.pop_front();
            check($sformatf("rd_valid[%0d]", k), 64'(vld), 64'd1);
            check($sformatf("rd_err[%0d]", k), 64'(er), 64'(e[32]));
            check($sformatf("rd_data[%0d] ch%0d sel%0d", k, rd_ch, rd_sel), 64'(dat), 64'(e[31:0]));
         end else begin
            check($sformatf("rd_valid_quiet[%0d]", k), 64'(vld), 64'd0);
         end
         check($sformatf("all_idle[%0d]", k), 64'(idl), 64'(want_idl));
      end
   endtask

   task automatic run(int n);
      for (int j = 0; j < n; j++) cycle();
   endtask

   task automatic idle_in();
      ap_start    = '0;
      ap_done     = '0;
      ap_ready    = '0;
      ap_continue = '1;
      finish      = 1'b0;
      clr         = 1'b0;
      rd_req      = 1'b0;
      rd_ch       = '0;
      rd_sel      = '0;
   endtask

   task automatic rd_expect(string name, int ch, int sel, longint want0, longint want1);
      rd_req = 1'b1;
      rd_ch  = 5'(ch);
      rd_sel = 3'(sel);
      cycle();
      rd_req = 1'b0;
      check({name, "_w32"}, 64'(rd_data0), 64'(want0));
      check({name, "_w4"}, 64'(rd_data1), 64'(want1));
   endtask

   initial begin
      vecs[0]  = '{0, 0, 32'd1, 1'b0};
      vecs[1]  = '{0, 1, 32'd4, 1'b0};
      vecs[2]  = '{0, 2, 32'd0, 1'b0};
      vecs[3]  = '{0, 3, 32'd5, 1'b0};
      vecs[4]  = '{0, 4, 32'd5, 1'b0};
      vecs[5]  = '{0, 5, 32'd5, 1'b0};
      vecs[6]  = '{4, 6, 32'd3, 1'b0};
      vecs[7]  = '{3, 5, 32'hFFFF_FFFF, 1'b0};
      vecs[8]  = '{7, 0, 32'd0, 1'b1};
      vecs[9]  = '{5, 3, 32'd0, 1'b1};
      vecs[10] = '{0, 7, 32'd0, 1'b1};

      mx[0] = 64'hFFFF_FFFF;
      mx[1] = 15;
      model_reset();
      idle_in();

      reset = 1'b0;
      run(3);
      check("reset_rd_valid", 64'(rd_valid0), 64'd0);
      check("reset_rd_data", 64'(rd_data0), 64'd0);
      check("reset_rd_err", 64'(rd_err0), 64'd0);
      check("reset_all_idle", 64'(all_idle0), 64'h1F);
      reset = 1'b1;
      run(2);
      rd_expect("reset_min", 1, 5, 64'hFFFF_FFFF, 15);

      // channel 0: start, three quiet cycles, done+continue -> latency 5, busy 4
      ap_start[0] = 1'b1;
      cycle();
      ap_start[0] = 1'b0;
      ap_ready[4] = 1'b1;
      run(3);
      ap_ready[4] = 1'b0;
      ap_done[0]  = 1'b1;
      cycle();
      ap_done[0]  = 1'b0;
      for (int v = 0; v < 11; v++) begin
         rd_req = 1'b1;
         rd_ch  = 5'(vecs[v].ch);
         rd_sel = 3'(vecs[v].sel);
         cycle();
         rd_req = 1'b0;
         check($sformatf("vec%0d_valid", v), 64'(rd_valid0), 64'd1);
         check($sformatf("vec%0d_data", v), 64'(rd_data0), 64'(vecs[v].data));
         check($sformatf("vec%0d_err", v), 64'(rd_err0), 64'(vecs[v].err));
      end

      // channel 2: done with continue held low for three cycles
      ap_start[2] = 1'b1;
      cycle();
      ap_start[2] = 1'b0;
      run(2);
      ap_done[2]     = 1'b1;
      ap_continue[2] = 1'b0;
      cycle();
      ap_done[2]     = 1'b0;
      for (int j = 0; j < 2; j++) begin
         cycle();
         check("stall_busy_flag", 64'(all_idle0[2]), 64'd0);
      end
      ap_continue[2] = 1'b1;
      cycle();
      check("stall_release_idle", 64'(all_idle0[2]), 64'd1);
      rd_expect("ch2_stall", 2, 2, 3, 3);
      rd_expect("ch2_last", 2, 3, 4, 4);
      rd_expect("ch2_txn", 2, 0, 1, 1);

      // channel 1: start held, back-to-back completions
      ap_start[1] = 1'b1;
      cycle();
      for (int t = 0; t < 4; t++) begin
         cycle();
         ap_done[1] = 1'b1;
         if (t == 3) ap_start[1] = 1'b0;
         cycle();
         ap_done[1] = 1'b0;
         check($sformatf("b2b_idle_t%0d", t), 64'(all_idle0[1]), 64'(t == 3));
      end
      rd_expect("b2b_txn", 1, 0, 4, 4);
      rd_expect("b2b_last", 1, 3, 3, 3);
      rd_expect("b2b_min", 1, 5, 3, 3);
      rd_expect("b2b_max", 1, 4, 3, 3);
      rd_expect("b2b_busy", 1, 1, 8, 8);

      // channel 3: 20 short transactions saturate the 4-bit txn counter
      for (int n = 0; n < 20; n++) begin
         ap_start[3] = 1'b1;
         cycle();
         ap_start[3] = 1'b0;
         ap_done[3]  = 1'b1;
         cycle();
         ap_done[3]  = 1'b0;
      end
      rd_expect("sat_txn", 3, 0, 20, 15);
      rd_expect("sat_min", 3, 5, 2, 2);
      rd_expect("sat_max", 3, 4, 2, 2);

      // channel 4: a 20-cycle transaction saturates the 4-bit latency
      ap_start[4] = 1'b1;
      cycle();
      ap_start[4] = 1'b0;
      run(18);
      ap_done[4] = 1'b1;
      cycle();
      ap_done[4] = 1'b0;
      rd_expect("sat_last", 4, 3, 20, 15);
      rd_expect("sat_busy", 4, 1, 19, 15);

      // clr on the same edge as a completion
      ap_start[0] = 1'b1;
      cycle();
      ap_start[0] = 1'b0;
      ap_done[0]  = 1'b1;
      clr         = 1'b1;
      cycle();
      ap_done[0]  = 1'b0;
      clr         = 1'b0;
      check("clr_idle", 64'(all_idle0[0]), 64'd1);
      rd_expect("clr_txn", 0, 0, 0, 0);
      rd_expect("clr_busy", 0, 1, 0, 0);
      rd_expect("clr_last", 0, 3, 0, 0);
      rd_expect("clr_max", 0, 4, 0, 0);
      rd_expect("clr_min", 0, 5, 64'hFFFF_FFFF, 15);
      rd_expect("clr_ch3", 3, 0, 0, 0);

      // finish freezes statistics while the FSM keeps tracking
      finish      = 1'b1;
      ap_ready[0] = 1'b1;
      ap_start[0] = 1'b1;
      cycle();
      ap_start[0] = 1'b0;
      check("finish_busy_state", 64'(all_idle0[0]), 64'd0);
      run(2);
      ap_done[0] = 1'b1;
      cycle();
      ap_done[0]  = 1'b0;
      ap_ready[0] = 1'b0;
      check("finish_back_idle", 64'(all_idle0[0]), 64'd1);
      rd_expect("finish_txn", 0, 0, 0, 0);
      rd_expect("finish_busy", 0, 1, 0, 0);
      rd_expect("finish_ready", 0, 6, 0, 0);
      finish = 1'b0;

      // reset in the middle of a busy transaction
      ap_start[2] = 1'b1;
      cycle();
      ap_start[2] = 1'b0;
      check("pre_reset_busy", 64'(all_idle0[2]), 64'd0);
      ap_done[2] = 1'b1;
      reset      = 1'b0;
      cycle();
      reset      = 1'b1;
      ap_done[2] = 1'b0;
      check("mid_reset_idle", 64'(all_idle0), 64'h1F);
      rd_expect("mid_reset_txn", 2, 0, 0, 0);

      // randomized handshakes, reads, clr, finish and rare resets
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NCH; i++) begin
            ap_start[i]    = ($urandom_range(0, 3) == 0);
            ap_done[i]     = ($urandom_range(0, 2) == 0);
            ap_continue[i] = ($urandom_range(0, 3) != 0);
            ap_ready[i]    = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 39) == 0) finish = !finish;
         clr    = !finish && ($urandom_range(0, 149) == 0);
         reset  = ($urandom_range(0, 699) != 0);
         rd_req = 1'($urandom_range(0, 1));
         rd_ch  = 5'($urandom_range(0, 7));
         rd_sel = 3'($urandom_range(0, 7));
         cycle();
      end
      idle_in();
      reset = 1'b1;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
